// File: rtl/img_pkg.sv
// img_pkg: shared constants and FSM state type for the BMP image sink.
package img_pkg;
  localparam int BMP_HDR_BYTES = 54;
  localparam int PIX_W = 8;
  typedef enum logic [1:0] {IDLE, CAPTURE, DUMP, DONE} state_t;
endpackage

// File: rtl/bmp_header_rom.sv
// bmp_header_rom: combinational 54-byte little-endian BMP/DIB header for a 24-bpp image.
module bmp_header_rom
  import img_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic [5:0]       idx,
  output logic [PIX_W-1:0] hdr
);
  localparam logic [31:0] IMG_BYTES  = 32'(3 * WIDTH * HEIGHT);
  localparam logic [31:0] FILE_BYTES = IMG_BYTES + 32'(BMP_HDR_BYTES);
  logic [31:0] word;
  logic [5:0]  start;
  logic [1:0]  sh;
  // each multi-byte field is picked by range, then the byte lane is its offset from the field start
  always_comb begin
    word  = '0;
    start = '0;
    if (idx inside {[2:5]}) begin word = FILE_BYTES; start = 6'd2; end
    else if (idx inside {[10:13]}) begin word = 32'(BMP_HDR_BYTES); start = 6'd10; end
    else if (idx inside {[14:17]}) begin word = 32'd40; start = 6'd14; end
    else if (idx inside {[18:21]}) begin word = 32'(WIDTH); start = 6'd18; end
    else if (idx inside {[22:25]}) begin word = 32'(HEIGHT); start = 6'd22; end
    else if (idx inside {[26:27]}) begin word = 32'd1; start = 6'd26; end
    else if (idx inside {[28:29]}) begin word = 32'd24; start = 6'd28; end
    else if (idx inside {[34:37]}) begin word = IMG_BYTES; start = 6'd34; end
    sh  = 2'(idx - start);
    hdr = idx == 6'd0 ? 8'h42 : idx == 6'd1 ? 8'h4D : 8'(word >> {sh, 3'b000});
  end
endmodule

// File: rtl/image_write.sv
// image_write: captures one frame of RGB pixel pairs and streams it out as a 24-bpp BMP file.
module image_write
  import img_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             VSYNC,
  input  logic             HSYNC,
  input  logic [PIX_W-1:0] DATA_R0,
  input  logic [PIX_W-1:0] DATA_G0,
  input  logic [PIX_W-1:0] DATA_B0,
  input  logic [PIX_W-1:0] DATA_R1,
  input  logic [PIX_W-1:0] DATA_G1,
  input  logic [PIX_W-1:0] DATA_B1,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [PIX_W-1:0] OUT_BYTE,
  output logic             OUT_LAST,
  output logic             WRITE_DONE,
  output logic             FRAME_ERR
);
  localparam int PAIRS     = WIDTH * HEIGHT / 2;
  localparam int MEM_BYTES = 3 * WIDTH * HEIGHT;
  localparam int PCW       = PAIRS > 1 ? $clog2(PAIRS) : 1;
  localparam int AW        = $clog2(MEM_BYTES);
  localparam logic [31:0] LAST_IDX = 32'(BMP_HDR_BYTES + MEM_BYTES - 1);

  logic [PIX_W-1:0] mem [MEM_BYTES];
  state_t           state_q, state_d;
  logic [PCW-1:0]   pair_cnt_q, pair_cnt_d;
  logic [31:0]      byte_idx_q, byte_idx_d, nxt_idx, row, col;
  logic [PIX_W-1:0] out_byte_q, out_byte_d, hdr_byte, rd_byte;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic             write_done_q, write_done_d, frame_err_q, frame_err_d, vsync_q;
  logic             wr_en, handshake, new_frame;
  logic [AW-1:0]    base;

  bmp_header_rom #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_hdr (.idx(nxt_idx[5:0]), .hdr(hdr_byte));

  // rows arrive top-down but BMP stores them bottom-up, so the row index is mirrored
  always_comb begin
    row       = 32'(pair_cnt_q) / 32'(WIDTH / 2);
    col       = 2 * (32'(pair_cnt_q) % 32'(WIDTH / 2));
    base      = AW'(3 * (32'(WIDTH) * (32'(HEIGHT - 1) - row) + col));
    wr_en     = state_q == CAPTURE && !VSYNC && HSYNC;
    handshake = out_valid_q && OUT_READY;
    nxt_idx   = handshake ? byte_idx_q + 32'd1 : byte_idx_q;
    rd_byte   = mem[AW'(nxt_idx - 32'(BMP_HDR_BYTES))];
    new_frame = (state_q == IDLE && VSYNC) || (state_q == DONE && VSYNC && !vsync_q);
  end

  always_comb begin
    state_d      = state_q;
    pair_cnt_d   = pair_cnt_q;
    byte_idx_d   = byte_idx_q;
    out_valid_d  = out_valid_q;
    out_byte_d   = out_byte_q;
    out_last_d   = out_last_q;
    write_done_d = write_done_q;
    frame_err_d  = (HSYNC && state_q != CAPTURE) || (frame_err_q && !new_frame);
    if (new_frame) begin
      state_d      = CAPTURE;
      pair_cnt_d   = '0;
      write_done_d = 1'b0;
    end
    if (state_q == CAPTURE && VSYNC) pair_cnt_d = '0;
    else if (wr_en) begin
      pair_cnt_d = pair_cnt_q == PCW'(PAIRS - 1) ? '0 : pair_cnt_q + 1'b1;
      if (pair_cnt_q == PCW'(PAIRS - 1)) begin
        state_d    = DUMP;
        byte_idx_d = '0;
      end
    end
    // output register reloads when empty or when its current byte is taken
    if (state_q == DUMP && (!out_valid_q || handshake)) begin
      if (out_valid_q && out_last_q) begin
        state_d      = DONE;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        out_byte_d   = '0;
        write_done_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        byte_idx_d  = nxt_idx;
        out_byte_d  = nxt_idx < 32'(BMP_HDR_BYTES) ? hdr_byte : rd_byte;
        out_last_d  = nxt_idx == LAST_IDX;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      pair_cnt_q   <= '0;
      byte_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= '0;
      out_last_q   <= 1'b0;
      write_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pair_cnt_q   <= pair_cnt_d;
      byte_idx_q   <= byte_idx_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
      out_last_q   <= out_last_d;
      write_done_q <= write_done_d;
      frame_err_q  <= frame_err_d;
      vsync_q      <= VSYNC;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      mem[base]          <= DATA_B0;
      mem[base + AW'(1)] <= DATA_G0;
      mem[base + AW'(2)] <= DATA_R0;
      mem[base + AW'(3)] <= DATA_B1;
      mem[base + AW'(4)] <= DATA_G1;
      mem[base + AW'(5)] <= DATA_R1;
    end
  end

  assign OUT_VALID  = out_valid_q;
  assign OUT_BYTE   = out_byte_q;
  assign OUT_LAST   = out_last_q;
  assign WRITE_DONE = write_done_q;
  assign FRAME_ERR  = frame_err_q;
endmodule
